// File: rtl/resp_diff_pkg.sv
// Shared types and helpers for the response diff checker: run states, MISR defaults,
// slice folding and lowest-set-bit search (inputs zero-extended to MAX_W by callers).
package resp_diff_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [31:0] POLY_DEF = 32'h04C11DB7;
  localparam logic [31:0] SEED_DEF = 32'hFFFFFFFF;
  localparam int MAX_W   = 1024;
  localparam int MAX_SIG = 64;

  // XOR of consecutive sig_w-bit slices; bits beyond the real width are zero.
  function automatic logic [MAX_SIG-1:0] fold_slices(input logic [MAX_W-1:0] y,
                                                     input int sig_w);
    logic [MAX_SIG-1:0] f;
    f = '0;
    for (int i = 0; i < MAX_W; i++) begin
      f[i % sig_w] = f[i % sig_w] ^ y[i];
    end
    return f;
  endfunction

  function automatic logic [15:0] lowest_set_index(input logic [MAX_W-1:0] d);
    logic [15:0] idx;
    idx = '0;
    for (int i = MAX_W - 1; i >= 0; i--) begin
      if (d[i]) idx = 16'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/resp_diff_checker_misr.sv
// Folds a wide response word into SIG_W bits and accumulates it in a MISR.
// One-cycle latency per enabled word; no backpressure, clr wins over en.
module resp_misr
  import resp_diff_pkg::*;
#(
  parameter int W = 481,
  parameter int SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY = POLY_DEF,
  parameter logic [SIG_W-1:0] SEED = SEED_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [W-1:0]     y,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] fold;
  logic [SIG_W-1:0] sig_next;

  always_comb begin
    fold     = SIG_W'(fold_slices(MAX_W'(y), SIG_W));
    sig_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ fold;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)   sig <= SEED;
    else if (clr) sig <= SEED;
    else if (en)  sig <= sig_next;
  end

endmodule

// File: rtl/resp_diff_checker.sv
// Compares reference and netlist responses per accepted sample, records the first divergence,
// keeps per-side MISR signatures; results land one cycle after acceptance, never stalls the driver.
module resp_diff_checker
  import resp_diff_pkg::*;
#(
  parameter int W = 481,
  parameter int SIG_W = 32,
  parameter logic [SIG_W-1:0] POLY = POLY_DEF,
  parameter logic [SIG_W-1:0] SEED = SEED_DEF,
  parameter int CNT_W = 16,
  parameter int BIT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             smp_valid,
  input  logic             smp_last,
  input  logic [W-1:0]     y_ref,
  input  logic [W-1:0]     y_dut,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] first_bad_cycle,
  output logic [BIT_W-1:0] first_bad_bit,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [CNT_W-1:0] sample_count,
  output logic [SIG_W-1:0] sig_ref,
  output logic [SIG_W-1:0] sig_dut
);

  state_t state_q, state_d;
  logic [W-1:0] diff;
  logic acc;
  logic clr_run;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (smp_valid && smp_last) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign acc     = busy && smp_valid;
  assign clr_run = start && !busy;
  assign pass    = done && !mismatch && (sig_ref == sig_dut);

  // Case inequality so X/Z on either side in simulation counts as a differing bit.
  always_comb begin
    diff = '0;
    for (int i = 0; i < W; i++) begin
      diff[i] = (y_ref[i] !== y_dut[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_run) begin
      mismatch        <= 1'b0;
      first_bad_cycle <= '0;
      first_bad_bit   <= '0;
      mismatch_count  <= '0;
      sample_count    <= '0;
    end else if (acc) begin
      if (sample_count != '1) sample_count <= sample_count + CNT_W'(1);
      if (|diff) begin
        if (mismatch_count != '1) mismatch_count <= mismatch_count + CNT_W'(1);
        if (!mismatch) begin
          mismatch        <= 1'b1;
          first_bad_cycle <= sample_count;
          first_bad_bit   <= BIT_W'(lowest_set_index(MAX_W'(diff)));
        end
      end
    end
  end

  resp_misr #(.W(W), .SIG_W(SIG_W), .POLY(POLY), .SEED(SEED)) u_misr_ref (
    .clk(clk), .rst_n(rst_n), .clr(clr_run), .en(acc), .y(y_ref), .sig(sig_ref)
  );

  resp_misr #(.W(W), .SIG_W(SIG_W), .POLY(POLY), .SEED(SEED)) u_misr_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr_run), .en(acc), .y(y_dut), .sig(sig_dut)
  );

endmodule

// File: tb/tb_resp_diff_checker.sv
// Directed bench: table of per-cycle vectors plus hand-written reset, signature and saturation sequences.
module tb_resp_diff_checker;

  localparam logic [31:0] SEED = 32'hFFFFFFFF;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, smp_valid, smp_last;
  logic [480:0] y_ref, y_dut;
  logic busy, done, pass, mismatch;
  logic [15:0] first_bad_cycle, mismatch_count, sample_count;
  logic [8:0] first_bad_bit;
  logic [31:0] sig_ref, sig_dut;

  logic s_start, s_valid, s_last;
  logic [63:0] s_yr, s_yd;
  logic s_busy, s_done, s_pass, s_mm;
  logic [2:0] s_fbc, s_mmc, s_sc;
  logic [5:0] s_fbb;
  logic [31:0] s_sig_ref, s_sig_dut;

  resp_diff_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .smp_valid(smp_valid), .smp_last(smp_last),
    .y_ref(y_ref), .y_dut(y_dut), .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
    .first_bad_cycle(first_bad_cycle), .first_bad_bit(first_bad_bit),
    .mismatch_count(mismatch_count), .sample_count(sample_count),
    .sig_ref(sig_ref), .sig_dut(sig_dut)
  );

  resp_diff_checker #(.W(64), .CNT_W(3), .BIT_W(6)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .smp_valid(s_valid), .smp_last(s_last),
    .y_ref(s_yr), .y_dut(s_yd), .busy(s_busy), .done(s_done), .pass(s_pass), .mismatch(s_mm),
    .first_bad_cycle(s_fbc), .first_bad_bit(s_fbb),
    .mismatch_count(s_mmc), .sample_count(s_sc),
    .sig_ref(s_sig_ref), .sig_dut(s_sig_dut)
  );

  typedef struct {
    bit st, vl, ls;
    int f1, f2;
    bit acc, clr, busy, done, mm, pass;
    int sc, mmc, fbc, fbb;
  } vec_t;

  int checks = 0;
  int failures = 0;
  logic [31:0] mref, mdut;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [480:0] rnd();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[32*k +: 32] = $urandom;
    return r[480:0];
  endfunction

  // Reference MISR step written straight from the slice-fold formula.
  function automatic logic [31:0] sig_step(input logic [31:0] s, input logic [480:0] y);
    logic [511:0] yp;
    logic [31:0] f;
    yp = {31'b0, y};
    f = '0;
    for (int k = 0; k < 16; k++) f = f ^ yp[32*k +: 32];
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
  endfunction

  task automatic do_row(input string tag, input vec_t v);
    start = v.st; smp_valid = v.vl; smp_last = v.ls;
    y_ref = rnd();
    y_dut = y_ref;
    if (v.f1 >= 0) y_dut[v.f1] = ~y_dut[v.f1];
    if (v.f2 >= 0) y_dut[v.f2] = ~y_dut[v.f2];
    if (v.clr) begin
      mref = SEED; mdut = SEED;
    end else if (v.acc) begin
      mref = sig_step(mref, y_ref); mdut = sig_step(mdut, y_dut);
    end
    tick();
    start = 0; smp_valid = 0; smp_last = 0;
    chk({tag, " busy"}, 64'(busy), 64'(v.busy));
    chk({tag, " done"}, 64'(done), 64'(v.done));
    chk({tag, " pass"}, 64'(pass), 64'(v.pass));
    chk({tag, " mismatch"}, 64'(mismatch), 64'(v.mm));
    chk({tag, " sample_count"}, 64'(sample_count), 64'(v.sc));
    chk({tag, " mismatch_count"}, 64'(mismatch_count), 64'(v.mmc));
    chk({tag, " first_bad_cycle"}, 64'(first_bad_cycle), 64'(v.fbc));
    chk({tag, " first_bad_bit"}, 64'(first_bad_bit), 64'(v.fbb));
    chk({tag, " sig_ref"}, 64'(sig_ref), 64'(mref));
    chk({tag, " sig_dut"}, 64'(sig_dut), 64'(mdut));
  endtask

  task automatic chk_reset_vals(input string tag);
    vec_t z;
    z = '{0,0,0,-1,-1, 0,0, 0,0,0,0, 0,0,0,0};
    chk({tag, " busy"}, 64'(busy), 64'(z.busy));
    chk({tag, " done"}, 64'(done), 64'(z.done));
    chk({tag, " pass"}, 64'(pass), 64'(z.pass));
    chk({tag, " mismatch"}, 64'(mismatch), 64'(z.mm));
    chk({tag, " sample_count"}, 64'(sample_count), 64'(z.sc));
    chk({tag, " mismatch_count"}, 64'(mismatch_count), 64'(z.mmc));
    chk({tag, " first_bad_cycle"}, 64'(first_bad_cycle), 64'(z.fbc));
    chk({tag, " first_bad_bit"}, 64'(first_bad_bit), 64'(z.fbb));
    chk({tag, " sig_ref"}, 64'(sig_ref), 64'(SEED));
    chk({tag, " sig_dut"}, 64'(sig_dut), 64'(SEED));
  endtask

  vec_t tbl[$];

  initial begin
    // st vl ls f1 f2 | acc clr | busy done mm pass | sc mmc fbc fbb
    tbl.push_back('{0,1,0,-1,-1, 0,0, 0,0,0,0,  0,0,0,0}); // valid in IDLE ignored
    tbl.push_back('{1,0,0,-1,-1, 0,1, 1,0,0,0,  0,0,0,0});
    tbl.push_back('{0,1,0,-1,-1, 1,0, 1,0,0,0,  1,0,0,0});
    tbl.push_back('{0,1,0,-1,-1, 1,0, 1,0,0,0,  2,0,0,0});
    tbl.push_back('{0,1,0, 7, 2, 1,0, 1,0,1,0,  3,1,2,2}); // sample 2: bits 7 and 2
    tbl.push_back('{1,1,0,-1,-1, 1,0, 1,0,1,0,  4,1,2,2}); // start in RUN ignored
    tbl.push_back('{0,0,0,-1,-1, 0,0, 1,0,1,0,  4,1,2,2});
    tbl.push_back('{0,1,0,-1,-1, 1,0, 1,0,1,0,  5,1,2,2});
    tbl.push_back('{0,1,0,-1,-1, 1,0, 1,0,1,0,  6,1,2,2});
    tbl.push_back('{0,1,0,-1,-1, 1,0, 1,0,1,0,  7,1,2,2});
    tbl.push_back('{0,1,0,-1,-1, 1,0, 1,0,1,0,  8,1,2,2});
    tbl.push_back('{0,1,0,-1,-1, 1,0, 1,0,1,0,  9,1,2,2});
    tbl.push_back('{0,1,0, 0,-1, 1,0, 1,0,1,0, 10,2,2,2}); // sample 9: bit 0
    tbl.push_back('{0,1,1,-1,-1, 1,0, 0,1,1,0, 11,2,2,2});
    tbl.push_back('{0,1,0,-1,-1, 0,0, 0,1,1,0, 11,2,2,2}); // DONE holds
    tbl.push_back('{1,1,0,-1,-1, 0,1, 1,0,0,0,  0,0,0,0}); // restart after failed run

    rst_n = 0; start = 0; smp_valid = 0; smp_last = 0; y_ref = '0; y_dut = '0;
    s_start = 0; s_valid = 0; s_last = 0; s_yr = '0; s_yd = '0;
    mref = SEED; mdut = SEED;
    tick();
    tick();
    chk_reset_vals("reset");
    chk("reset s_sig_ref", 64'(s_sig_ref), 64'(SEED));
    rst_n = 1;

    foreach (tbl[i]) do_row($sformatf("tbl[%0d]", i), tbl[i]);

    // Matched stream of 21 samples.
    for (int i = 0; i < 21; i++)
      do_row($sformatf("match[%0d]", i),
             '{0,1,(i == 20),-1,-1, 1,0, (i != 20),(i == 20),0,(i == 20), i + 1,0,0,0});

    // Single-bit divergence at sample 5, bit 300.
    do_row("div start", '{1,0,0,-1,-1, 0,1, 1,0,0,0, 0,0,0,0});
    for (int i = 0; i < 21; i++)
      do_row($sformatf("div[%0d]", i),
             '{0,1,(i == 20),(i == 5) ? 300 : -1,-1, 1,0, (i != 20),(i == 20),(i >= 5),0,
               i + 1,(i >= 5) ? 1 : 0,(i >= 5) ? 5 : 0,(i >= 5) ? 300 : 0});

    // Reset mid-run after 4 samples with a mismatch.
    do_row("rst start", '{1,0,0,-1,-1, 0,1, 1,0,0,0, 0,0,0,0});
    for (int i = 0; i < 4; i++)
      do_row($sformatf("rst[%0d]", i),
             '{0,1,0,(i == 1) ? 10 : -1,-1, 1,0, 1,0,(i >= 1),0,
               i + 1,(i >= 1) ? 1 : 0,(i >= 1) ? 1 : 0,(i >= 1) ? 10 : 0});
    rst_n = 0;
    mref = SEED; mdut = SEED;
    tick();
    chk_reset_vals("midrst");
    rst_n = 1;
    do_row("post valid", '{0,1,0,-1,-1, 0,0, 0,0,0,0, 0,0,0,0});
    do_row("post start", '{1,0,0,-1,-1, 0,1, 1,0,0,0, 0,0,0,0});
    for (int i = 0; i < 3; i++)
      do_row($sformatf("post[%0d]", i),
             '{0,1,(i == 2),-1,-1, 1,0, (i != 2),(i == 2),0,(i == 2), i + 1,0,0,0});

    // Narrow instance: known signature value, then counter saturation.
    s_start = 1;
    tick();
    s_start = 0;
    s_valid = 1; s_yr = 64'h00000001_00000000; s_yd = 64'h00000001_00000000;
    tick();
    chk("sig64 ref", 64'(s_sig_ref), 64'h00000000_FB3EE248);
    chk("sig64 dut", 64'(s_sig_dut), 64'h00000000_FB3EE248);
    chk("sig64 sc", 64'(s_sc), 64'd1);
    for (int i = 0; i < 7; i++) begin
      s_yr = {$urandom, $urandom}; s_yd = s_yr;
      tick();
    end
    chk("sat sc", 64'(s_sc), 64'd7);
    chk("sat mm clean", 64'(s_mm), 64'd0);
    for (int i = 0; i < 9; i++) begin
      s_yr = {$urandom, $urandom}; s_yd = s_yr ^ 64'h8;
      s_last = (i == 8);
      tick();
    end
    s_valid = 0; s_last = 0;
    chk("sat fbc", 64'(s_fbc), 64'd7);
    chk("sat fbb", 64'(s_fbb), 64'd3);
    chk("sat mmc", 64'(s_mmc), 64'd7);
    chk("sat sc2", 64'(s_sc), 64'd7);
    chk("sat done", 64'(s_done), 64'd1);
    chk("sat pass", 64'(s_pass), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
